// File: rtl/hex_entry_controller.sv
// Five-button hex entry controller: synchronize, debounce, edge-detect
// and edit a 32-nibble value. Macro AUTO_REPEAT_EN enables up/down repeat.
module hex_entry_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic         btn_center,
    input  logic         clr,
    output logic [127:0] data,
    output logic         data_valid,
    output logic         editing,
    output logic [4:0]   cursor,
    output logic [2:0]   digit_sel
);

    // Button bit order: 0 up, 1 down, 2 left, 3 right, 4 center
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {IDLE, EDIT} state_t;

    logic [4:0]    raw;
    logic [4:0]    s1_q, s2_q;
    logic [4:0]    stb_q, stb_prev_q;
    logic [4:0]    press_q;
    logic [CW-1:0] cnt_q [5];
    logic [4:0]    ev;

    state_t        state_q;
    logic [127:0]  data_q;
    logic [4:0]    cursor_q;
    logic          valid_q;
    logic [6:0]    msb;
    logic [3:0]    cur_nib;

    assign raw = {btn_center, btn_right, btn_left, btn_down, btn_up};

    // Two-flop synchronizers, counter debouncers and rising-edge press pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            stb_q      <= '0;
            stb_prev_q <= '0;
            press_q    <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            s1_q       <= raw;
            s2_q       <= s1_q;
            stb_prev_q <= stb_q;
            press_q    <= stb_q & ~stb_prev_q;
            for (int i = 0; i < 5; i++) begin
                if (s2_q[i] == stb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DB_LAST) begin
                    cnt_q[i] <= '0;
                    stb_q[i] <= s2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [RW-1:0] R_DLY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_RT  = RW'(REPEAT_RATE);

    logic [RW-1:0] rcnt_q [2];
    logic [1:0]    rphase_q;
    logic [1:0]    rep_q;

    // Hold timers for up/down; first repeat after the delay, then at the rate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rphase_q <= '0;
            rep_q    <= '0;
            for (int i = 0; i < 2; i++) rcnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rep_q[i] <= 1'b0;
                if (stb_q[i] && state_q == EDIT) begin
                    if (rcnt_q[i] == (rphase_q[i] ? R_RT : R_DLY)) begin
                        rep_q[i]    <= 1'b1;
                        rcnt_q[i]   <= RW'(1);
                        rphase_q[i] <= 1'b1;
                    end else begin
                        rcnt_q[i] <= rcnt_q[i] + 1'b1;
                    end
                end else begin
                    rcnt_q[i]   <= '0;
                    rphase_q[i] <= 1'b0;
                end
            end
        end
    end

    assign ev = {press_q[4:2], press_q[1:0] | rep_q};
`else
    assign ev = press_q;
`endif

    assign msb     = 7'd127 - {cursor_q, 2'b00};
    assign cur_nib = data_q[msb -: 4];

    // Edit FSM: one event per cycle, center > up > down > right > left
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            data_q   <= '0;
            cursor_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (clr) begin
                state_q  <= IDLE;
                data_q   <= '0;
                cursor_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ev[4]) begin
                            state_q  <= EDIT;
                            cursor_q <= '0;
                        end
                    end
                    EDIT: begin
                        if (ev[4]) begin
                            state_q <= IDLE;
                            valid_q <= 1'b1;
                        end else if (ev[0]) begin
                            data_q[msb -: 4] <= cur_nib + 4'd1;
                        end else if (ev[1]) begin
                            data_q[msb -: 4] <= cur_nib - 4'd1;
                        end else if (ev[3]) begin
                            cursor_q <= cursor_q + 5'd1;
                        end else if (ev[2]) begin
                            cursor_q <= cursor_q - 5'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign editing    = (state_q == EDIT);
    assign cursor     = cursor_q;
    assign digit_sel  = {1'b0, cursor_q[4:3]};

endmodule

// File: doc/hex_entry_controller.md
HEX_ENTRY_CONTROLLER -- requirements
Module: hex_entry_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, cycles a synchronized button must differ from its debounced state before that state flips.
REQ-002 SHALL have parameter REPEAT_DELAY, default 50000000, hold cycles before the first auto-repeat.
REQ-003 SHALL have parameter REPEAT_RATE, default 10000000, cycles between subsequent auto-repeats.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 btn_up, btn_down, btn_left, btn_right, btn_center  input  1 each  raw asynchronous pushbuttons, active-high.
REQ-007 clr  input  1  synchronous clear, active-high.
REQ-008 data  output  128  entered value; nibble k (k=0..31) is data[127-4k -: 4], nibble 0 is MSB.
REQ-009 data_valid  output  1  one-cycle pulse on commit.
REQ-010 editing  output  1  high while in EDIT.
REQ-011 cursor  output  5  index of the nibble being edited.
REQ-012 digit_sel  output  3  {1'b0, cursor[4:3]}, selects the 8-digit display group containing the cursor.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then a per-button debouncer: the counter increments while sync != stable, clears when they are equal, and stable flips when the count reaches DEBOUNCE_CYCLES.
REQ-014 A press event SHALL be a registered one-cycle pulse on a 0->1 transition of the debounced state; releases generate no event.
REQ-015 Latency from a clean raw rising edge to the resulting data/cursor/editing change SHALL be DEBOUNCE_CYCLES+4 cycles.
REQ-016 The FSM SHALL have states IDLE and EDIT.
- IDLE: center -> EDIT with cursor=0; all other events ignored.
- EDIT: handles the events in REQ-017 to REQ-019.
REQ-017 In EDIT, up SHALL increment nibble[cursor] mod 16 (F->0), and down SHALL decrement it mod 16 (0->F); other nibbles are unchanged.
REQ-018 In EDIT, right SHALL move cursor +1 mod 32 (31->0), and left SHALL move cursor -1 mod 32 (0->31).
REQ-019 In EDIT, center SHALL return to IDLE and pulse data_valid for exactly the cycle editing falls; data is unchanged by commit.
REQ-020 Simultaneous events SHALL be resolved by priority center > up > down > right > left; exactly one is applied per cycle and the others are discarded.
REQ-021 clr SHALL force data=0, cursor=0, state=IDLE and data_valid=0 on the next edge; clr SHALL override any event in the same cycle.
REQ-022 data and cursor SHALL hold their values in IDLE; a re-entry to EDIT resets cursor to 0 but keeps data.

Reset
REQ-023 On rst_n low, the block SHALL immediately set data=0, cursor=0, digit_sel=0, data_valid=0, editing=0 and state=IDLE.
REQ-024 On rst_n low, the block SHALL clear all synchronizer flops, debounced states, debounce counters and repeat counters.
REQ-025 A button held through reset deassertion SHALL produce one press event DEBOUNCE_CYCLES+3 cycles after release of reset.
REQ-026 A reset asserted mid-press or mid-debounce SHALL discard that pending event.

Configuration
REQ-027 The macro AUTO_REPEAT_EN SHALL control auto-repeat.
- Defined: while in EDIT with debounced up or down held continuously, one extra event fires after REPEAT_DELAY cycles, then every REPEAT_RATE cycles until release.
- Defined: left, right and center never repeat.
- Not defined: exactly one event per press, and no repeat counters are synthesized.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8)
REQ-028 Reset, then hold center 10 cycles -> editing=1 exactly 8 cycles after the raw edge; cursor=0, data=0.
REQ-029 In EDIT at cursor 0, press up 3 times -> data[127:124]=3; then press down 4 times -> data[127:124]=F; data[123:0] stays 0.
REQ-030 In EDIT at cursor 0, press left -> cursor=31, digit_sel=3; then up -> data[3:0]=1.
REQ-031 Pulse up high for 2 cycles -> no event, data unchanged; raise up and right on the same cycle -> only the nibble increments, cursor unchanged.
REQ-032 In EDIT, press center -> editing falls, data_valid high exactly 1 cycle, data stable; assert clr with a concurrent up event -> data=0, IDLE.
REQ-033 With AUTO_REPEAT_EN defined, hold up for 44 cycles past debounce -> nibble advances by 4 (press at debounce, then +20, +28, +36); without the macro it advances by 1.
